// File: rtl/age_lru_ctrl_pkg.sv
// Shared cache LRU configuration: way/set widths, age-vector layout and
// controller state encodings.
package age_lru_ctrl_pkg;

  localparam int C_N_WAY       = 3;
  localparam int SET_ADDR_WDTH = 5;
  localparam int N_WAYS        = 1 << C_N_WAY;
  localparam int N_SETS        = 1 << SET_ADDR_WDTH;
  localparam int AGE_VEC_WDTH  = N_WAYS * C_N_WAY;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/age_lru_ctrl_update.sv
// lru_age_update: picks the target way (hit way or oldest way) and ages
// the set so the target becomes MRU.
module lru_age_update
  import age_lru_ctrl_pkg::*;
(
  input  logic [AGE_VEC_WDTH-1:0] ages,
  input  logic                    hit,
  input  logic [C_N_WAY-1:0]      way,
  output logic [C_N_WAY-1:0]      target,
  output logic [AGE_VEC_WDTH-1:0] new_ages
);

  logic [C_N_WAY-1:0] victim;
  logic [C_N_WAY-1:0] max_age;
  logic [C_N_WAY-1:0] tgt_age;

  // Strict '>' keeps the lowest index among equal maxima; an all-ones age is
  // the maximum, so this also yields the lowest-index LRU way.
  always_comb begin
    victim  = '0;
    max_age = ages[C_N_WAY-1:0];
    for (int i = 1; i < N_WAYS; i++) begin
      if (ages[i*C_N_WAY +: C_N_WAY] > max_age) begin
        max_age = ages[i*C_N_WAY +: C_N_WAY];
        victim  = C_N_WAY'(i);
      end
    end
  end

  assign target  = hit ? way : victim;
  assign tgt_age = ages[target*C_N_WAY +: C_N_WAY];

  always_comb begin
    new_ages = ages;
    for (int i = 0; i < N_WAYS; i++) begin
      if (C_N_WAY'(i) == target) begin
        new_ages[i*C_N_WAY +: C_N_WAY] = '0;
      end else if (ages[i*C_N_WAY +: C_N_WAY] < tgt_age) begin
        new_ages[i*C_N_WAY +: C_N_WAY] = ages[i*C_N_WAY +: C_N_WAY] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/age_lru_ctrl.sv
// LRU age-memory sequencer: waits out the memory clear, then reads, updates
// and writes back one set per cycle with single-level write forwarding.
//
// state   | meaning
// ST_INIT | age memory clearing, req_ready low
// ST_RUN  | accepting one lookup per cycle
module age_lru_ctrl
  import age_lru_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [SET_ADDR_WDTH-1:0] req_set,
  input  logic                     req_hit,
  input  logic [C_N_WAY-1:0]       req_way,
  output logic                     resp_valid,
  output logic [C_N_WAY-1:0]       resp_way,
  output logic                     resp_miss,
  output logic [SET_ADDR_WDTH-1:0] mem_r_addr,
  input  logic [AGE_VEC_WDTH-1:0]  mem_r_data,
  output logic [SET_ADDR_WDTH-1:0] mem_w_addr,
  output logic [AGE_VEC_WDTH-1:0]  mem_w_data,
  output logic                     mem_w_en
);

  ctrl_state_t              state;
  logic [SET_ADDR_WDTH-1:0] init_cnt;

  logic                     s1_valid;
  logic [SET_ADDR_WDTH-1:0] s1_set;
  logic                     s1_hit;
  logic [C_N_WAY-1:0]       s1_way;

  logic                     fwd_valid;
  logic [SET_ADDR_WDTH-1:0] fwd_set;
  logic [AGE_VEC_WDTH-1:0]  fwd_data;

  logic [AGE_VEC_WDTH-1:0]  src_ages;
  logic [AGE_VEC_WDTH-1:0]  upd_ages;
  logic [C_N_WAY-1:0]       upd_target;
  logic                     accept;
  logic                     s1_live;

  assign accept     = req_valid & req_ready;
  assign mem_r_addr = req_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      req_ready <= 1'b0;
    end else if (state == ST_INIT) begin
      if (init_cnt == '1) begin
        state     <= ST_RUN;
        req_ready <= 1'b1;
      end else begin
        init_cnt <= init_cnt + 1'b1;
      end
    end else begin
      req_ready <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_set    <= '0;
      s1_hit    <= 1'b0;
      s1_way    <= '0;
      fwd_valid <= 1'b0;
      fwd_set   <= '0;
      fwd_data  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_set <= req_set;
        s1_hit <= req_hit;
        s1_way <= req_way;
      end
      fwd_valid <= s1_valid;
      fwd_set   <= s1_set;
      fwd_data  <= upd_ages;
    end
  end

  // The memory returns stale data when last cycle's write hit this set.
  assign src_ages = (fwd_valid && (fwd_set == s1_set)) ? fwd_data : mem_r_data;

  lru_age_update u_update (
    .ages     (src_ages),
    .hit      (s1_hit),
    .way      (s1_way),
    .target   (upd_target),
    .new_ages (upd_ages)
  );

  // Reset in the response cycle drops the in-flight update outright.
  assign s1_live    = s1_valid & ~reset;
  assign resp_valid = s1_live;
  assign resp_way   = s1_live ? upd_target : '0;
  assign resp_miss  = s1_live & ~s1_hit;
  assign mem_w_en   = s1_live;
  assign mem_w_addr = s1_live ? s1_set : '0;
  assign mem_w_data = s1_live ? upd_ages : '0;

endmodule

// File: tb/tb_age_lru_ctrl.sv
// Bench for age_lru_ctrl: behavioural age memory plus a per-set LRU
// reference model driven by directed and random lookups.
module tb_age_lru_ctrl;
  import age_lru_ctrl_pkg::*;

  logic                     clk;
  logic                     reset;
  logic                     req_valid;
  logic                     req_ready;
  logic [SET_ADDR_WDTH-1:0] req_set;
  logic                     req_hit;
  logic [C_N_WAY-1:0]       req_way;
  logic                     resp_valid;
  logic [C_N_WAY-1:0]       resp_way;
  logic                     resp_miss;
  logic [SET_ADDR_WDTH-1:0] mem_r_addr;
  logic [AGE_VEC_WDTH-1:0]  mem_r_data;
  logic [SET_ADDR_WDTH-1:0] mem_w_addr;
  logic [AGE_VEC_WDTH-1:0]  mem_w_data;
  logic                     mem_w_en;

  int n_checks = 0;
  int n_errors = 0;

  age_lru_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_set    (req_set),
    .req_hit    (req_hit),
    .req_way    (req_way),
    .resp_valid (resp_valid),
    .resp_way   (resp_way),
    .resp_miss  (resp_miss),
    .mem_r_addr (mem_r_addr),
    .mem_r_data (mem_r_data),
    .mem_w_addr (mem_w_addr),
    .mem_w_data (mem_w_data),
    .mem_w_en   (mem_w_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AGE_VEC_WDTH-1:0] fresh_vec();
    logic [AGE_VEC_WDTH-1:0] v;
    for (int i = 0; i < N_WAYS; i++) v[i*C_N_WAY +: C_N_WAY] = C_N_WAY'(N_WAYS - 1 - i);
    return v;
  endfunction

  // Age memory: registered read, read-before-write on a same-address collision.
  logic [AGE_VEC_WDTH-1:0] mem [N_SETS];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_SETS; i++) mem[i] <= fresh_vec();
    end else if (mem_w_en) begin
      mem[mem_w_addr] <= mem_w_data;
    end
    mem_r_data <= mem[mem_r_addr];
  end

  // Reference model: plain per-set age arrays updated in request order.
  int                      ages_m [N_SETS][N_WAYS];
  bit                      exp_valid;
  int                      exp_way;
  bit                      exp_miss;
  int                      exp_set;
  logic [AGE_VEC_WDTH-1:0] exp_data;

  task automatic model_fresh();
    for (int s = 0; s < N_SETS; s++)
      for (int i = 0; i < N_WAYS; i++) ages_m[s][i] = N_WAYS - 1 - i;
    exp_valid = 0;
  endtask

  task automatic model_access(input int s, input bit hit, input int w);
    int tgt;
    int a;
    int mx;
    if (hit) begin
      tgt = w;
    end else begin
      tgt = -1;
      for (int i = 0; i < N_WAYS; i++)
        if (tgt < 0 && ages_m[s][i] == N_WAYS - 1) tgt = i;
      if (tgt < 0) begin
        mx = -1;
        for (int i = 0; i < N_WAYS; i++)
          if (ages_m[s][i] > mx) begin mx = ages_m[s][i]; tgt = i; end
      end
    end
    a = ages_m[s][tgt];
    for (int i = 0; i < N_WAYS; i++) begin
      if (i == tgt) ages_m[s][i] = 0;
      else if (ages_m[s][i] < a) ages_m[s][i] = ages_m[s][i] + 1;
    end
    for (int i = 0; i < N_WAYS; i++) exp_data[i*C_N_WAY +: C_N_WAY] = C_N_WAY'(ages_m[s][i]);
    exp_way  = tgt;
    exp_miss = !hit;
    exp_set  = s;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_resp();
    chk("resp_valid", 32'(resp_valid), 32'(exp_valid));
    chk("mem_w_en", 32'(mem_w_en), 32'(exp_valid));
    if (exp_valid) begin
      chk("resp_way", 32'(resp_way), 32'(exp_way));
      chk("resp_miss", 32'(resp_miss), 32'(exp_miss));
      chk("mem_w_addr", 32'(mem_w_addr), 32'(exp_set));
      chk("mem_w_data", 32'(mem_w_data), 32'(exp_data));
    end
  endtask

  // One cycle: check last cycle's response, then present a new request.
  task automatic step(input bit v, input int s, input bit h, input int w);
    @(negedge clk);
    check_resp();
    req_valid = v;
    req_set   = SET_ADDR_WDTH'(s);
    req_hit   = h;
    req_way   = C_N_WAY'(w);
    exp_valid = v && req_ready;
    if (exp_valid) model_access(s, h, w);
    #1;
    chk("mem_r_addr", 32'(mem_r_addr), 32'(s));
  endtask

  // Called at a negedge with reset just dropped: measure the clear window.
  task automatic wait_init();
    int  n;
    bit  saw_wen;
    n = 0;
    saw_wen = 0;
    while (!req_ready && n < 100) begin
      if (mem_w_en) saw_wen = 1;
      n++;
      @(negedge clk);
    end
    chk("init_len", 32'(n), 32'd32);
    chk("init_wen", 32'(saw_wen), 32'd0);
    chk("ready_up", 32'(req_ready), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_fresh();
    wait_init();
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_set   = '0;
    req_hit   = 1'b0;
    req_way   = '0;
    model_fresh();
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_miss", 32'(resp_miss), 32'd0);
    chk("rst_resp_way", 32'(resp_way), 32'd0);
    chk("rst_w_en", 32'(mem_w_en), 32'd0);
    chk("rst_w_addr", 32'(mem_w_addr), 32'd0);
    chk("rst_w_data", 32'(mem_w_data), 32'd0);
    reset = 1'b0;
    wait_init();

    // Fresh miss, then back-to-back forwarded miss on set 3.
    step(1, 3, 0, 0);
    step(1, 3, 0, 0);
    step(0, 0, 0, 0);

    // Hit on way 5 in a fresh set.
    step(1, 9, 1, 5);
    step(0, 0, 0, 0);

    // A, B, A pattern from fresh: no false forward on B.
    do_reset();
    step(1, 3, 0, 0);
    step(1, 4, 0, 0);
    step(1, 3, 0, 0);
    step(0, 0, 0, 0);

    // Reset in the cycle after an accept drops the update.
    do_reset();
    step(1, 3, 0, 0);
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 1'b0;
    exp_valid = 0;
    #1;
    chk("rst_drop_valid", 32'(resp_valid), 32'd0);
    chk("rst_drop_wen", 32'(mem_w_en), 32'd0);
    @(negedge clk);
    chk("rst_drop_valid2", 32'(resp_valid), 32'd0);
    chk("rst_drop_wen2", 32'(mem_w_en), 32'd0);
    reset = 1'b0;
    model_fresh();
    wait_init();
    step(1, 3, 0, 0);
    step(0, 0, 0, 0);

    // Random traffic concentrated on a few sets to exercise forwarding.
    for (int k = 0; k < 400; k++) begin
      int s;
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N_SETS - 1))
                                      : int'($urandom_range(0, 3));
      step($urandom_range(0, 9) != 0, s, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, N_WAYS - 1)));
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
